// File: rtl/hex_keypad_scanner_if.sv
// hex_keypad_scanner_if
//   Key-code handshake between the keypad scanner and the logic that consumes keys.
//   Signals:
//     code        4-bit decoded key (4*row_index + col_index)
//     code_valid  code holds a key that has not been consumed yet
//     code_ack    consumer takes the current code (only meaningful while code_valid=1)
//     overrun     one-cycle pulse: a key was decoded but dropped because code was still pending
//   Modports:
//     master  the scanner (drives code/code_valid/overrun, reads code_ack)
//     slave   the consumer (reads code/code_valid/overrun, drives code_ack)
interface hex_keypad_scanner_if;
    logic [3:0] code;
    logic       code_valid;
    logic       code_ack;
    logic       overrun;

    modport master (
        output code,
        output code_valid,
        output overrun,
        input  code_ack
    );

    modport slave (
        input  code,
        input  code_valid,
        input  overrun,
        output code_ack
    );
endinterface

// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner
//   Scans a 4x4 hex keypad. All columns are driven while waiting for a press;
//   once a press has been stable for DEBOUNCE_CYCLES, the columns are driven
//   one at a time to locate the key. The key is then presented as a 4-bit code
//   with a valid/ack handshake, and the scanner waits for a debounced release
//   before accepting the next press, so a held key produces exactly one code.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     row   keypad row lines (asynchronous, active-high)
//     col   keypad column drive (active-high)
//     kbus  key-code handshake (master side: code, code_valid, overrun out; code_ack in)
module hex_keypad_scanner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SETTLE_CYCLES   = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  row,
    output logic [3:0]                  col,
    hex_keypad_scanner_if.master        kbus
);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        SCAN,
        DECODE,
        RELEASE
    } state_t;

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);
    // With a single debounce cycle the press seen in IDLE already satisfies debounce.
    localparam bit DEB_SINGLE = (DEBOUNCE_CYCLES <= 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [SW-1:0] scnt, scnt_n;
    logic [1:0]    col_idx, col_idx_n;
    logic [1:0]    key_row, key_row_n;
    logic [3:0]    row_m, row_s;

    // Lowest set row wins when several keys share the scanned column.
    function automatic logic [1:0] lowest_row(input logic [3:0] r);
        if (r[0])      return 2'd0;
        else if (r[1]) return 2'd1;
        else if (r[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Two-flop synchronizer for the asynchronous row lines; everything downstream uses row_s.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_m <= '0;
            row_s <= '0;
        end else begin
            row_m <= row;
            row_s <= row_m;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            scnt    <= '0;
            col_idx <= '0;
            key_row <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            scnt    <= scnt_n;
            col_idx <= col_idx_n;
            key_row <= key_row_n;
        end
    end

    // Next-state logic. cnt is shared between press debounce and release debounce;
    // scnt counts settle cycles for the column currently driven in SCAN.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        scnt_n    = scnt;
        col_idx_n = col_idx;
        key_row_n = key_row;
        case (state)
            IDLE: begin
                if (row_s != 4'b0000) begin
                    if (DEB_SINGLE) begin
                        state_n   = SCAN;
                        col_idx_n = 2'd0;
                        scnt_n    = '0;
                        cnt_n     = '0;
                    end else begin
                        state_n = DEBOUNCE;
                        cnt_n   = CW'(1);
                    end
                end
            end
            DEBOUNCE: begin
                if (row_s == 4'b0000) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    // This cycle is the DEBOUNCE_CYCLES-th consecutive non-zero sample.
                    state_n   = SCAN;
                    col_idx_n = 2'd0;
                    scnt_n    = '0;
                    cnt_n     = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            SCAN: begin
                // row_s reflects the current column only after the synchronizer has
                // flushed, so the sample is taken on the last settle cycle.
                if (scnt == SET_LAST) begin
                    scnt_n = '0;
                    if (row_s != 4'b0000) begin
                        key_row_n = lowest_row(row_s);
                        state_n   = DECODE;
                    end else if (col_idx == 2'd3) begin
                        state_n = IDLE;
                    end else begin
                        col_idx_n = col_idx + 2'd1;
                    end
                end else begin
                    scnt_n = scnt + SW'(1);
                end
            end
            DECODE: begin
                state_n = RELEASE;
                cnt_n   = '0;
            end
            RELEASE: begin
                if (row_s != 4'b0000) begin
                    cnt_n = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                scnt_n  = '0;
            end
        endcase
    end

    // Columns are all driven except while scanning, so any press is visible in IDLE/RELEASE.
    always_comb begin
        col = 4'b1111;
        if (state == SCAN) begin
            col = 4'b0001 << col_idx;
        end
    end

    // Output handshake. A decode either loads the code (free slot, or consumer acking in
    // the same cycle) or is dropped with an overrun pulse; otherwise an ack frees the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kbus.code       <= '0;
            kbus.code_valid <= 1'b0;
            kbus.overrun    <= 1'b0;
        end else begin
            kbus.overrun <= 1'b0;
            if (state == DECODE) begin
                if (!kbus.code_valid || kbus.code_ack) begin
                    kbus.code       <= {key_row, col_idx};
                    kbus.code_valid <= 1'b1;
                end else begin
                    kbus.overrun <= 1'b1;
                end
            end else if (kbus.code_ack && kbus.code_valid) begin
                kbus.code_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// tb_hex_keypad_scanner
//   Drives the keypad from a 16-bit key vector through the electrical row/column model
//   and compares the scanner's handshake outputs against a key-level reference model:
//   expected code from column-then-row priority, expected timing from the press latency
//   formula, and the pending/overrun behaviour of the single-entry code slot.
module tb_hex_keypad_scanner;

    localparam int DEB = 4;
    localparam int SET = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] keys;
    logic [3:0]  row;
    logic [3:0]  col;

    int          checks = 0;
    int          errors = 0;

    // Reference model of the code slot.
    logic        mValid;
    logic [3:0]  mCode;

    hex_keypad_scanner_if kbus ();

    hex_keypad_scanner #(
        .DEBOUNCE_CYCLES (DEB),
        .SETTLE_CYCLES   (SET)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .row  (row),
        .col  (col),
        .kbus (kbus)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a row line is high when any pressed key on it sits in a driven column.
    always_comb begin
        row = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4*r+c] && col[c]) row[r] = 1'b1;
            end
        end
    end

    // First column in scan order wins, lowest row within it.
    function automatic int keyCode(input logic [15:0] k);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (k[4*r+c]) return 4*r + c;
            end
        end
        return -1;
    endfunction

    function automatic int pressLatency(input int code);
        return 2 + DEB + ((code % 4) + 1) * SET + 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] k);
        tick();
        keys = k;
    endtask

    task automatic releaseKeys();
        keys = 16'h0000;
        repeat (12) tick();
    endtask

    // Press a key set cleanly; the decode is expected exactly pressLatency cycles later.
    task automatic pressCheck(input string tag, input logic [15:0] k, input bit ackInDecode);
        int   code;
        int   lat;
        logic expOv;
        code = keyCode(k);
        lat  = pressLatency(code);
        applyStimulus(k);
        repeat (lat - 1) tick();
        checkOutput({tag, " pre valid"}, 32'(kbus.code_valid), 32'(mValid));
        checkOutput({tag, " pre code"}, 32'(kbus.code), 32'(mCode));
        kbus.code_ack = ackInDecode;
        tick();
        kbus.code_ack = 1'b0;
        if (!mValid || ackInDecode) begin
            mCode  = 4'(code);
            mValid = 1'b1;
            expOv  = 1'b0;
        end else begin
            expOv = 1'b1;
        end
        checkOutput({tag, " code"}, 32'(kbus.code), 32'(mCode));
        checkOutput({tag, " valid"}, 32'(kbus.code_valid), 32'(mValid));
        checkOutput({tag, " overrun"}, 32'(kbus.overrun), 32'(expOv));
        checkOutput({tag, " col"}, 32'(col), 32'hf);
        tick();
        checkOutput({tag, " overrun pulse"}, 32'(kbus.overrun), 32'h0);
    endtask

    task automatic doAck(input string tag);
        kbus.code_ack = 1'b1;
        tick();
        kbus.code_ack = 1'b0;
        mValid = 1'b0;
        checkOutput({tag, " ack valid"}, 32'(kbus.code_valid), 32'h0);
        checkOutput({tag, " ack code"}, 32'(kbus.code), 32'(mCode));
    endtask

    task automatic waitCol(input string tag, input logic [3:0] want);
        int n = 0;
        while (col !== want && n < 60) begin
            tick();
            n++;
        end
        checkOutput({tag, " col reached"}, 32'(col), 32'(want));
    endtask

    initial begin
        int vcount;
        int ocount;
        logic [15:0] rk;
        bit ra;

        rst           = 1'b1;
        keys          = 16'h0000;
        kbus.code_ack = 1'b0;
        mValid        = 1'b0;
        mCode         = 4'h0;
        repeat (3) tick();
        checkOutput("reset col", 32'(col), 32'hf);
        checkOutput("reset code", 32'(kbus.code), 32'h0);
        checkOutput("reset valid", 32'(kbus.code_valid), 32'h0);
        checkOutput("reset overrun", 32'(kbus.overrun), 32'h0);
        rst = 1'b0;
        repeat (3) tick();

        // Key 9 clean press, ack, then held with no repeat.
        pressCheck("key9", 16'h1 << 9, 1'b0);
        doAck("key9");
        vcount = 0;
        ocount = 0;
        repeat (50) begin
            tick();
            vcount += int'(kbus.code_valid);
            ocount += int'(kbus.overrun);
        end
        checkOutput("hold valid count", 32'(vcount), 32'h0);
        checkOutput("hold overrun count", 32'(ocount), 32'h0);
        releaseKeys();

        // Sweep every key.
        for (int k = 0; k < 16; k++) begin
            pressCheck($sformatf("sweep%0d", k), 16'h1 << k, 1'b0);
            doAck($sformatf("sweep%0d", k));
            releaseKeys();
        end

        // Bounce on key 5: a short burst must not produce a code; the clean re-press does.
        applyStimulus(16'h1 << 5);
        repeat (3) tick();
        keys = 16'h0000;
        repeat (3) tick();
        pressCheck("bounce5", 16'h1 << 5, 1'b0);
        doAck("bounce5");
        releaseKeys();

        // Key 14 lost while column 1 is being scanned.
        applyStimulus(16'h1 << 14);
        waitCol("lost14", 4'b0010);
        keys = 16'h0000;
        vcount = 0;
        repeat (25) begin
            tick();
            vcount += int'(kbus.code_valid);
        end
        checkOutput("lost14 valid count", 32'(vcount), 32'h0);
        checkOutput("lost14 col", 32'(col), 32'hf);
        releaseKeys();

        // Pending key 3, then key 7 without ack (overrun) and with ack in DECODE.
        pressCheck("pend3", 16'h1 << 3, 1'b0);
        releaseKeys();
        pressCheck("ovr7", 16'h1 << 7, 1'b0);
        releaseKeys();
        pressCheck("ack7", 16'h1 << 7, 1'b1);
        releaseKeys();
        doAck("ack7");

        // Keys 6 and 8 together; then reset in the middle of scanning column 2.
        pressCheck("multi68", (16'h1 << 6) | (16'h1 << 8), 1'b0);
        releaseKeys();
        applyStimulus(16'h1 << 6);
        waitCol("rst6", 4'b0100);
        rst = 1'b1;
        #1;
        checkOutput("midrst col", 32'(col), 32'hf);
        checkOutput("midrst valid", 32'(kbus.code_valid), 32'h0);
        checkOutput("midrst code", 32'(kbus.code), 32'h0);
        tick();
        rst    = 1'b0;
        mValid = 1'b0;
        mCode  = 4'h0;
        releaseKeys();

        // Random key sets with random ack timing.
        for (int i = 0; i < 12; i++) begin
            rk = 16'($urandom_range(1, 65535));
            ra = 1'($urandom_range(0, 1));
            pressCheck($sformatf("rnd%0d", i), rk, ra);
            releaseKeys();
            if ($urandom_range(0, 1) == 1) doAck($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
